// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit. Streams 8-byte lines from the L1I into a
// two-entry line FIFO and carves them into 16/32-bit instructions for decode.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic        re_o,
  output logic [31:0] raddr_o,
  input  logic        l1_re_i,
  input  logic [63:0] l1_rdata_i,
  input  logic [31:0] l1_raddr_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_c_o
);

  logic [31:0] pc_q, pc_d;
  logic [63:0] d0_q, d0_d, d1_q, d1_d;
  logic [31:0] a0_q, a0_d, a1_q, a1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        infl_q, infl_d;
  logic [1:0]  off_q, off_d;

  logic        req;
  logic [15:0] head_hw;
  logic [31:0] raw32;
  logic        is32;
  logic        valid;
  logic        fire;
  logic [2:0]  adv;
  logic        pop;
  logic        push;

  // Request issue, instruction extraction and handshake decode
  always_comb begin
    req = rst & ~jump_flag_i & ~hold_flag_i &
          (({1'b0, cnt_q} + {2'b00, infl_q}) < 3'd2);
    re_o    = req;
    raddr_o = req ? pc_q : '0;

    unique case (off_q)
      2'd0: begin head_hw = d0_q[15:0];  raw32 = d0_q[31:0];               end
      2'd1: begin head_hw = d0_q[31:16]; raw32 = d0_q[47:16];              end
      2'd2: begin head_hw = d0_q[47:32]; raw32 = d0_q[63:32];              end
      default: begin head_hw = d0_q[63:48]; raw32 = {d1_q[15:0], d0_q[63:48]}; end
    endcase

    is32  = (head_hw[1:0] == 2'b11);
    valid = rst & ~jump_flag_i & (cnt_q != 2'd0) &
            (~is32 | (off_q != 2'd3) | (cnt_q == 2'd2));

    inst_valid_o = valid;
    inst_o       = valid ? (is32 ? raw32 : {16'h0000, head_hw}) : '0;
    inst_addr_o  = valid ? (a0_q + {29'd0, off_q, 1'b0}) : '0;
    inst_c_o     = valid & ~is32;

    fire = valid & inst_ready_i;
    adv  = {1'b0, off_q} + (is32 ? 3'd2 : 3'd1);
    pop  = fire & adv[2];
    push = rst & ~jump_flag_i & l1_re_i;
  end

  // Next-state: PC, in-flight tracking, offset and FIFO push/pop
  always_comb begin
    pc_d   = pc_q;
    d0_d   = d0_q;
    d1_d   = d1_q;
    a0_d   = a0_q;
    a1_d   = a1_q;
    cnt_d  = cnt_q;
    infl_d = infl_q;
    off_d  = off_q;

    if (jump_flag_i) begin
      pc_d   = {jump_addr_i[31:3], 3'b000};
      off_d  = jump_addr_i[2:1];
      cnt_d  = '0;
      infl_d = 1'b0;
    end else begin
      if (req) begin
        pc_d = pc_q + 32'd8;
      end
      if (req) begin
        infl_d = 1'b1;
      end else if (l1_re_i) begin
        infl_d = 1'b0;
      end
      if (fire) begin
        off_d = adv[1:0];
      end
      // Simultaneous pop+push: the incoming line lands behind whatever survives the pop.
      unique case ({pop, push})
        2'b10: begin
          d0_d  = d1_q;
          a0_d  = a1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd0) begin
            d0_d = l1_rdata_i;
            a0_d = l1_raddr_i;
          end else begin
            d1_d = l1_rdata_i;
            a1_d = l1_raddr_i;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            d0_d = d1_q;
            a0_d = a1_q;
            d1_d = l1_rdata_i;
            a1_d = l1_raddr_i;
          end else begin
            d0_d = l1_rdata_i;
            a0_d = l1_raddr_i;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q   <= {RESET_PC[31:3], 3'b000};
      off_q  <= RESET_PC[2:1];
      cnt_q  <= '0;
      infl_q <= 1'b0;
      d0_q   <= '0;
      d1_q   <= '0;
      a0_q   <= '0;
      a1_q   <= '0;
    end else begin
      pc_q   <= pc_d;
      off_q  <= off_d;
      cnt_q  <= cnt_d;
      infl_q <= infl_d;
      d0_q   <= d0_d;
      d1_q   <= d1_d;
      a0_q   <= a0_d;
      a1_q   <= a1_d;
    end
  end

endmodule
